// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master and its SCK generator.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam logic SPI_IDLE_MOSI = 1'b1;
  localparam int   SPI_BYTE_BITS = 8;
  localparam int   SPI_DIV_W     = 4;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: half-period counter, SCK toggle and rise/fall strobes.
// Held in its idle state (sck low, counter cleared) whenever en is low.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;
  logic             tc;

  assign tc   = (cnt_q == div);
  assign rise = en && tc && !sck_q;
  assign fall = en && tc && sck_q;
  assign sck  = sck_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (tc) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dma_master.sv
// Byte-wide SPI master for the DMA SPI device port with direct Z80 port access.
// Optional runtime divider register enabled by defining SPI_DIV_REG_EN.
//
// state | meaning
// IDLE  | waiting for a DMA request or Z80 data-port strobe; mosi held high
// SHIFT | shifting one byte; ends on the 8th falling SCK edge
module spi_dma_master
  import spi_pkg::*;
#(
  parameter int DIV   = 0,
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_req,
  input  logic [7:0] spi_wrdata,
  output logic [7:0] spi_rddata,
  output logic       spi_stb,
  output logic       spi_start,
  input  logic [7:0] zdata,
  input  logic       zspi_wr,
  input  logic       zspi_rd,
  input  logic       zcs_wr,
`ifdef SPI_DIV_REG_EN
  input  logic       zdiv_wr,
`endif
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [DIV_W-1:0] DIV_L = DIV_W'(DIV);

  spi_state_e       state_q, state_d;
  logic [7:0]       tx_q, rx_q, tx_d, rddata_q;
  logic [3:0]       bit_cnt_q;
  logic             cs_n_q, load, rise, fall, done;
  logic [DIV_W-1:0] div_q;

`ifdef SPI_DIV_REG_EN
  logic [DIV_W-1:0] div_reg_q;

  // The active divider is only sampled at acceptance so a byte never changes rate mid-flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg_q <= DIV_L;
      div_q     <= DIV_L;
    end else begin
      if (zdiv_wr) div_reg_q <= zdata[DIV_W-1:0];
      if (load)    div_q     <= div_reg_q;
    end
  end
`else
  assign div_q = DIV_L;
`endif

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .div   (div_q),
    .sck   (sck),
    .rise  (rise),
    .fall  (fall)
  );

  assign busy       = (state_q == SHIFT);
  assign done       = busy && fall && (bit_cnt_q == 4'(SPI_BYTE_BITS));
  assign spi_stb    = done;
  assign spi_rddata = rddata_q;
  assign cs_n       = cs_n_q;
  assign mosi       = busy ? tx_q[7] : SPI_IDLE_MOSI;

  always_comb begin
    state_d   = state_q;
    spi_start = 1'b0;
    load      = 1'b0;
    tx_d      = 8'hFF;
    case (state_q)
      IDLE: begin
        if (spi_req) begin
          state_d   = SHIFT;
          spi_start = 1'b1;
          load      = 1'b1;
          tx_d      = spi_wrdata;
        end else if (zspi_wr) begin
          state_d = SHIFT;
          load    = 1'b1;
          tx_d    = zdata;
        end else if (zspi_rd) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 8'hFF;
      rx_q      <= 8'hFF;
      bit_cnt_q <= '0;
      rddata_q  <= 8'hFF;
      cs_n_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (zcs_wr) cs_n_q <= zdata[0];
      if (load) begin
        tx_q      <= tx_d;
        bit_cnt_q <= '0;
      end else if (busy) begin
        if (rise) begin
          rx_q      <= {rx_q[6:0], miso};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        if (fall) tx_q <= {tx_q[6:0], 1'b1};
      end
      if (done) rddata_q <= rx_q;
    end
  end

endmodule
